// File: rtl/pixel_window3x3_pkg.sv
// Shared pixel definitions for the image pipeline.
// Holds the default pixel width and the 3x3 window index constants
// (k = 3*row + col, row 0 = oldest line, col 0 = oldest column).
// No ports; imported by the window generator and its line buffers.
package pixel_window3x3_pkg;

    localparam int PIX_W_DEF = 8;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_C  = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    // Flat window slot for neighbourhood row r, column c.
    function automatic int win_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/pixel_window3x3_line_buffer.sv
// One image line of pixel storage.
// Single port: asynchronous read and synchronous write share one address.
// Ports:
//   clk      in   clock, write on rising edge
//   we_i     in   write enable
//   addr_i   in   column address (read and write)
//   wdata_i  in   pixel to store
//   rdata_o  out  pixel currently stored at addr_i (value before any write this cycle)
module pixel_window3x3_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [PIX_W-1:0]  wdata_i,
    output logic [PIX_W-1:0]  rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; rows 0-1 of every frame refill it
    // before any window can use it, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/pixel_window3x3.sv
// Streaming 3x3 neighbourhood generator.
// Accepts one raster-order pixel per valid cycle, keeps the two previous lines
// in line buffers and emits a full 3x3 window one cycle after each pixel that
// completes a neighbourhood (row >= 2 and col >= 2).
// Ports:
//   clk         in   clock, all logic on rising edge
//   rst         in   synchronous active-high reset
//   in_valid    in   in_pixel accepted this cycle
//   in_sof      in   with in_valid: pixel is (0,0) of a new frame
//   in_pixel    in   raster-order pixel
//   win_valid   out  window holds a complete neighbourhood
//   window      out  window[PIX_W*k +: PIX_W], k = 3*r + c, k=8 newest pixel
//   frame_done  out  one-cycle pulse after pixel (H-1, W-1) is accepted
module pixel_window3x3
    import pixel_window3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [PIX_W-1:0]   in_pixel,
    output logic               win_valid,
    output logic [9*PIX_W-1:0] window,
    output logic               frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0]   col_q, col_d, cur_col;
    logic [ROW_W-1:0]   row_q, row_d, cur_row;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [9*PIX_W-1:0] window_q, window_d;

    logic               lb_we;
    logic [PIX_W-1:0]   lb0_rdata, lb1_rdata;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    assign cur_col = in_sof ? '0 : col_q;
    assign cur_row = in_sof ? '0 : row_q;
    assign lb_we   = in_valid & ~rst;

    // LB0 holds the previous line; LB1 receives what LB0 held at this column.
    pixel_window3x3_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W),
        .ADDR_W(COL_W)
    ) u_lb0 (
        .clk    (clk),
        .we_i   (lb_we),
        .addr_i (cur_col),
        .wdata_i(in_pixel),
        .rdata_o(lb0_rdata)
    );

    pixel_window3x3_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .PIX_W (PIX_W),
        .ADDR_W(COL_W)
    ) u_lb1 (
        .clk    (clk),
        .we_i   (lb_we),
        .addr_i (cur_col),
        .wdata_i(lb0_rdata),
        .rdata_o(lb1_rdata)
    );

    // NOTE: every variable gets its hold/idle value first so no path through
    // this block leaves one unassigned (which would infer a latch).
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (in_valid) begin
            // Pre-increment position decides validity; col < 2 blocks windows
            // that would mix stale columns from the previous line.
            win_valid_d = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            if (cur_col == COL_LAST) begin
                col_d = '0;
                if (cur_row == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = cur_row + ROW_W'(1);
                end
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    // Shift window columns left and insert the new column at c2.
    always_comb begin
        window_d = window_q;
        if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                window_d[PIX_W*win_idx(r, 0) +: PIX_W] = window_q[PIX_W*win_idx(r, 1) +: PIX_W];
                window_d[PIX_W*win_idx(r, 1) +: PIX_W] = window_q[PIX_W*win_idx(r, 2) +: PIX_W];
            end
            window_d[PIX_W*WIN_TR +: PIX_W] = lb1_rdata;
            window_d[PIX_W*WIN_MR +: PIX_W] = lb0_rdata;
            window_d[PIX_W*WIN_BR +: PIX_W] = in_pixel;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            window_q     <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            window_q     <= window_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign window     = window_q;

endmodule

// File: tb/tb_pixel_window3x3.sv
// Self-checking bench for pixel_window3x3 on a 4x4 image.
// Expected windows are built from the bench's own copy of the driven image and
// queued at drive time; they are popped and compared when win_valid appears.
module tb_pixel_window3x3;

    localparam int W = 4;
    localparam int H = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_sof;
    logic [PW-1:0] in_pixel;
    logic          win_valid;
    logic [9*PW-1:0] window;
    logic          frame_done;

    pixel_window3x3 #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PIX_W     (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .win_valid (win_valid),
        .window    (window),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [9*PW-1:0] exp_q[$];
    logic [PW-1:0]   img [H][W];
    int  mr, mc;            // model position of the next pixel
    bit  exp_wv, exp_fd;
    int  n_win, pix_cnt, first_win;

    task automatic check(input string tag, input logic [9*PW-1:0] got, input logic [9*PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mark();
        n_win     = 0;
        pix_cnt   = 0;
        first_win = -1;
    endtask

    // Drive one cycle, update the model, then compare the registered outputs.
    task automatic step(input bit v, input bit sof, input logic [PW-1:0] pix);
        logic [9*PW-1:0] w;
        in_valid = v;
        in_sof   = sof;
        in_pixel = pix;
        exp_wv   = 1'b0;
        exp_fd   = 1'b0;
        if (v) begin
            if (sof) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = pix;
            pix_cnt++;
            if (mr >= 2 && mc >= 2) begin
                exp_wv = 1'b1;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        w[PW*(3*rr+cc) +: PW] = img[mr-2+rr][mc-2+cc];
                exp_q.push_back(w);
            end
            exp_fd = (mr == H-1) && (mc == W-1);
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        @(posedge clk);
        #1;
        check("win_valid", {71'b0, win_valid}, {71'b0, exp_wv});
        check("frame_done", {71'b0, frame_done}, {71'b0, exp_fd});
        if (win_valid) begin
            n_win++;
            if (first_win < 0) first_win = pix_cnt;
            if (exp_q.size() > 0) check("window", window, exp_q.pop_front());
            else check("window_queue", 72'(exp_q.size()), 72'd1);
        end
    endtask

    task automatic rst_cycle();
        rst      = 1'b1;
        in_valid = 1'($urandom);
        in_sof   = 1'($urandom);
        in_pixel = PW'($urandom);
        @(posedge clk);
        #1;
        check("rst_win_valid", {71'b0, win_valid}, 72'd0);
        check("rst_window", window, 72'd0);
        check("rst_frame_done", {71'b0, frame_done}, 72'd0);
        mr  = 0;
        mc  = 0;
        rst = 1'b0;
    endtask

    // n pixels in raster order from (0,0); gap inserts an idle cycle after each.
    task automatic pixels(input int n, input bit first_sof, input bit gap, input bit rnd);
        for (int i = 0; i < n; i++) begin
            int r = (i / W) % H;
            int c = i % W;
            step(1'b1, first_sof && (i == 0), rnd ? PW'($urandom) : PW'(16 * r + c));
            if (gap) step(1'b0, 1'b0, PW'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        mr = 0; mc = 0;
        mark();

        // 1. Reset with random inputs.
        rst_cycle();
        rst_cycle();

        // 2. Continuous frame with sof on the first pixel.
        mark();
        pixels(W*H, 1'b1, 1'b0, 1'b0);
        check("t2_windows", 72'(n_win), 72'd4);
        check("t2_first_win", 72'(first_win), 72'd11);

        // 3. Same frame, valid every other cycle.
        mark();
        pixels(W*H, 1'b1, 1'b1, 1'b0);
        check("t3_windows", 72'(n_win), 72'd4);

        // 4. Two back-to-back frames, the second with random pixels.
        mark();
        pixels(W*H, 1'b1, 1'b0, 1'b0);
        pixels(W*H, 1'b0, 1'b0, 1'b1);
        check("t4_windows", 72'(n_win), 72'd8);

        // 5. sof at (1,2) restarts the frame.
        pixels(6, 1'b1, 1'b0, 1'b0);
        mark();
        pixels(W*H, 1'b1, 1'b0, 1'b0);
        check("t5_windows", 72'(n_win), 72'd4);
        check("t5_first_win", 72'(first_win), 72'd11);

        // 6. Reset at (2,3); next pixel becomes (0,0) without sof.
        pixels(11, 1'b1, 1'b0, 1'b0);
        rst_cycle();
        mark();
        pixels(W*H, 1'b0, 1'b0, 1'b1);
        check("t6_windows", 72'(n_win), 72'd4);
        check("t6_first_win", 72'(first_win), 72'd11);

        check("queue_drained", 72'(exp_q.size()), 72'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
